pe_array_sequencer: RTL and testbench

//  Upstream sequencer for the per-PE control FSMs (reset->load->ready->start).

---
 rtl/pe_array_sequencer_if.sv | 43 ++++
 rtl/pe_array_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pe_array_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_sequencer_if.sv
// Handshake and control bundle between the PE-array sequencer and its environment.
// master = job/weight source side, slave = sequencer side.
interface pe_array_sequencer_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RUN_WIDTH  = 16
);
  localparam int NUM_COL_WIDTH = $clog2(N + 1);

  logic                     go;
  logic                     abort;
  logic [NUM_COL_WIDTH-1:0] filter_size;
  logic [RUN_WIDTH-1:0]     run_len;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [DATA_WIDTH-1:0]    cfg_data;

  logic                     wr_en;
  logic [DATA_WIDTH-1:0]    weight;
  logic [NUM_COL_WIDTH-1:0] wr_row;
  logic [NUM_COL_WIDTH-1:0] wr_col;

  logic                     array_rst;
  logic                     load;
  logic                     ready;
  logic                     start_op;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output go, abort, filter_size, run_len, cfg_valid, cfg_data,
    input  cfg_ready, wr_en, weight, wr_row, wr_col,
           array_rst, load, ready, start_op, busy, done, err
  );

  modport slave (
    input  go, abort, filter_size, run_len, cfg_valid, cfg_data,
    output cfg_ready, wr_en, weight, wr_row, wr_col,
           array_rst, load, ready, start_op, busy, done, err
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Sequences the per-PE control FSMs: reset -> weight load -> ready -> start -> timed run -> reset.
// All outputs are registered Moore outputs, written for the state being entered.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | array held in reset, waiting for go
//   CLEAR | one reset cycle before load, or the reset cycle after abort
//   LOAD  | accepting K*K weight words, row-major
//   READY | one-cycle ready pulse to the PE control FSMs
//   START | one-cycle start_op pulse; run counter loaded
//   RUN   | counting run_len cycles
//   DRAIN | array returned to reset, done pulsed
module pe_array_sequencer #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RUN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pe_array_sequencer_if.slave   bus
);
  localparam int NUM_COL_WIDTH = $clog2(N + 1);
  localparam logic [NUM_COL_WIDTH-1:0] K_MAX = NUM_COL_WIDTH'(N);
  localparam logic [NUM_COL_WIDTH-1:0] ONE   = NUM_COL_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    READY = 3'd3,
    START = 3'd4,
    RUN   = 3'd5,
    DRAIN = 3'd6
  } state_t;

  state_t                   state;
  logic                     aborting;
  logic [NUM_COL_WIDTH-1:0] k;
  logic [RUN_WIDTH-1:0]     run_len_q;
  logic [RUN_WIDTH-1:0]     run_cnt;
  logic [NUM_COL_WIDTH-1:0] row;
  logic [NUM_COL_WIDTH-1:0] col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aborting      <= 1'b0;
      k             <= '0;
      run_len_q     <= '0;
      run_cnt       <= '0;
      row           <= '0;
      col           <= '0;
      bus.cfg_ready <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.weight    <= '0;
      bus.wr_row    <= '0;
      bus.wr_col    <= '0;
      bus.array_rst <= 1'b1;
      bus.load      <= 1'b0;
      bus.ready     <= 1'b0;
      bus.start_op  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.wr_en    <= 1'b0;
      bus.ready    <= 1'b0;
      bus.start_op <= 1'b0;
      bus.done     <= 1'b0;

      if (state != IDLE && bus.abort) begin
        // Abort discards partial progress and leaves through one reset cycle.
        state         <= CLEAR;
        aborting      <= 1'b1;
        bus.array_rst <= 1'b1;
        bus.load      <= 1'b0;
        bus.cfg_ready <= 1'b0;
        row           <= '0;
        col           <= '0;
        run_cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.go) begin
              if (bus.filter_size != '0 && bus.filter_size <= K_MAX) begin
                state     <= CLEAR;
                aborting  <= 1'b0;
                k         <= bus.filter_size;
                run_len_q <= bus.run_len;
                bus.err   <= 1'b0;
                bus.busy  <= 1'b1;
              end else begin
                bus.err <= 1'b1;
              end
            end
          end

          CLEAR: begin
            if (aborting) begin
              state    <= IDLE;
              aborting <= 1'b0;
              bus.busy <= 1'b0;
            end else begin
              state         <= LOAD;
              bus.array_rst <= 1'b0;
              bus.load      <= 1'b1;
              bus.cfg_ready <= 1'b1;
              row           <= ONE;
              col           <= ONE;
            end
          end

          LOAD: begin
            if (bus.cfg_valid && bus.cfg_ready) begin
              bus.wr_en  <= 1'b1;
              bus.weight <= bus.cfg_data;
              bus.wr_row <= row;
              bus.wr_col <= col;
              if (col == k) begin
                col <= ONE;
                if (row == k) begin
                  state         <= READY;
                  bus.load      <= 1'b0;
                  bus.cfg_ready <= 1'b0;
                  bus.ready     <= 1'b1;
                end else begin
                  row <= row + ONE;
                end
              end else begin
                col <= col + ONE;
              end
            end
          end

          READY: begin
            state        <= START;
            bus.start_op <= 1'b1;
            run_cnt      <= run_len_q;
          end

          START: begin
            if (run_cnt == '0) begin
              state         <= DRAIN;
              bus.array_rst <= 1'b1;
              bus.done      <= 1'b1;
            end else begin
              state <= RUN;
            end
          end

          RUN: begin
            // run_cnt is at least 1 on entry, so RUN lasts exactly run_len cycles.
            run_cnt <= run_cnt - RUN_WIDTH'(1);
            if (run_cnt == RUN_WIDTH'(1)) begin
              state         <= DRAIN;
              bus.array_rst <= 1'b1;
              bus.done      <= 1'b1;
            end
          end

          DRAIN: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end

          default: begin
            state         <= IDLE;
            bus.array_rst <= 1'b1;
            bus.busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scenario bench for pe_array_sequencer: weight writes are scoreboarded against a
// queue filled at handshake time, control pulses are checked cycle by cycle.
module tb_pe_array_sequencer;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [DW-1:0] w;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  pe_array_sequencer_if #(.N(N), .DATA_WIDTH(DW), .RUN_WIDTH(RW)) bus ();

  pe_array_sequencer #(.N(N), .DATA_WIDTH(DW), .RUN_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int kk, input int rl);
    bus.go          = 1'b1;
    bus.filter_size = CW'(kk);
    bus.run_len     = RW'(rl);
    tick();
    bus.go = 1'b0;
  endtask

  // Streams K*K words starting in the CLEAR cycle; returns in the START cycle.
  task automatic stream(input int kk, input bit toggle, input logic [DW-1:0] base);
    int r = 1, c = 1, sent = 0, cyc = 0, pops = 0, ready_cnt = 0;
    exp_t e;
    logic [DW-1:0] d;
    while ((sent < kk * kk || sb.size() > 0) && cyc < 400) begin
      tests++;
      if (bus.wr_en !== (sb.size() > 0)) begin
        fails++;
        $display("FAIL wr_en cyc %0d: got %b want %b", cyc, bus.wr_en, sb.size() > 0);
      end
      if (bus.wr_en === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        pops++;
        tests++;
        if ({bus.weight, bus.wr_row, bus.wr_col} !== {e.w, e.r, e.c}) begin
          fails++;
          $display("FAIL write: got w=%h (%0d,%0d) want w=%h (%0d,%0d)",
                   bus.weight, bus.wr_row, bus.wr_col, e.w, e.r, e.c);
        end
      end
      if (bus.ready === 1'b1) ready_cnt++;
      d = base + DW'(sent);
      bus.cfg_valid = (sent < kk * kk) && (!toggle || (cyc % 2 == 0));
      bus.cfg_data  = d;
      if (bus.cfg_valid && bus.cfg_ready === 1'b1) begin
        e.w = d;
        e.r = CW'(r);
        e.c = CW'(c);
        sb.push_back(e);
        sent++;
        if (c == kk) begin
          c = 1;
          r++;
        end else begin
          c++;
        end
      end
      tick();
      cyc++;
    end
    bus.cfg_valid = 1'b0;
    tests++;
    if (cyc >= 400 || pops != kk * kk) begin
      fails++;
      $display("FAIL load_count: got %0d writes in %0d cycles, want %0d", pops, cyc, kk * kk);
    end
    tests++;
    if (ready_cnt != 1) begin
      fails++;
      $display("FAIL ready_pulses: got %0d want 1", ready_cnt);
    end
    tests++;
    if ({bus.start_op, bus.ready, bus.load, bus.wr_en, bus.cfg_ready} !== 5'b10000) begin
      fails++;
      $display("FAIL start_cycle: got start/ready/load/wr/cfgr=%b want 10000",
               {bus.start_op, bus.ready, bus.load, bus.wr_en, bus.cfg_ready});
    end
  endtask

  // Called in the START cycle; returns in the IDLE cycle after DRAIN.
  task automatic run_phase(input int rl);
    int n = 0;
    tick();
    while (bus.done !== 1'b1 && n <= rl + 5) begin
      tests++;
      if ({bus.array_rst, bus.start_op, bus.ready, bus.load} !== 4'b0000) begin
        fails++;
        $display("FAIL run_strobes cyc %0d: got %b want 0000", n,
                 {bus.array_rst, bus.start_op, bus.ready, bus.load});
      end
      n++;
      tick();
    end
    tests++;
    if (n != rl || bus.array_rst !== 1'b1 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL run_len: got %0d run cycles rst=%b done=%b, want %0d 1 1",
               n, bus.array_rst, bus.done, rl);
    end
    tick();
    tests++;
    if ({bus.done, bus.busy, bus.array_rst} !== 3'b001) begin
      fails++;
      $display("FAIL after_drain: got done/busy/rst=%b want 001",
               {bus.done, bus.busy, bus.array_rst});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    tests++;
    if ({bus.array_rst, bus.cfg_ready, bus.wr_en, bus.load, bus.ready,
         bus.start_op, bus.busy, bus.done, bus.err} !== 9'b1_0000_0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 100000000",
               {bus.array_rst, bus.cfg_ready, bus.wr_en, bus.load, bus.ready,
                bus.start_op, bus.busy, bus.done, bus.err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_k3_full();
    start_job(3, 3);
    tests++;
    if ({bus.busy, bus.array_rst, bus.cfg_ready} !== 3'b110) begin
      fails++;
      $display("FAIL clear_state: got busy/rst/cfgr=%b want 110",
               {bus.busy, bus.array_rst, bus.cfg_ready});
    end
    stream(3, 1'b0, 8'h01);
    run_phase(3);
  endtask

  task automatic test_k2_toggle();
    start_job(2, 5);
    stream(2, 1'b1, 8'h20);
    // go while busy must be ignored, even with an illegal size
    bus.go = 1'b1;
    bus.filter_size = '0;
    run_phase(5);
    bus.go = 1'b0;
    tests++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL go_while_busy: got err=%b busy=%b want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_illegal_size();
    start_job(0, 1);
    tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL err_k0: got err=%b busy=%b want 1 0", bus.err, bus.busy);
    end
    tick();
    tick();
    tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.array_rst !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got err=%b busy=%b rst=%b want 1 0 1",
               bus.err, bus.busy, bus.array_rst);
    end
    start_job(1, 2);
    tests++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: got err=%b busy=%b want 0 1", bus.err, bus.busy);
    end
    stream(1, 1'b0, 8'hA0);
    run_phase(2);
  endtask

  task automatic test_abort();
    start_job(3, 4);
    tick();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'h11;
    tick();
    bus.cfg_data  = 8'h12;
    tick();
    bus.abort     = 1'b1;
    bus.cfg_data  = 8'h13;
    tick();
    bus.abort     = 1'b0;
    bus.cfg_valid = 1'b0;
    tests++;
    if ({bus.array_rst, bus.load, bus.cfg_ready, bus.wr_en, bus.done, bus.busy} !== 6'b100001) begin
      fails++;
      $display("FAIL abort_clear: got rst/load/cfgr/wr/done/busy=%b want 100001",
               {bus.array_rst, bus.load, bus.cfg_ready, bus.wr_en, bus.done, bus.busy});
    end
    tick();
    tests++;
    if ({bus.array_rst, bus.done, bus.busy} !== 3'b100) begin
      fails++;
      $display("FAIL abort_idle: got rst/done/busy=%b want 100",
               {bus.array_rst, bus.done, bus.busy});
    end
    start_job(2, 1);
    stream(2, 1'b0, 8'h40);
    run_phase(1);
  endtask

  task automatic test_async_reset();
    start_job(1, 20);
    stream(1, 1'b0, 8'h77);
    tick();
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.array_rst, bus.busy, bus.start_op, bus.load, bus.done, bus.wr_en} !== 6'b100000) begin
      fails++;
      $display("FAIL async_reset: got rst/busy/start/load/done/wr=%b want 100000",
               {bus.array_rst, bus.busy, bus.start_op, bus.load, bus.done, bus.wr_en});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    start_job(2, 0);
    stream(2, 1'b0, 8'hC0);
    run_phase(0);
  endtask

  initial begin
    bus.go          = 1'b0;
    bus.abort       = 1'b0;
    bus.filter_size = '0;
    bus.run_len     = '0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_data    = '0;
    test_reset();
    test_k3_full();
    test_k2_toggle();
    test_illegal_size();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
